// File: rtl/fpu_mul_issue_ctrl_if.sv
// Upstream operand and downstream result handshakes of the FP32 multiplier issue stage.
// The master drives operands and result-ready; the slave is the issue controller.
interface fpu_mul_issue_ctrl_if;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] Op_a;
    logic [31:0] Op_b;
    logic [1:0]  R_mode_in;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] Result;
    logic [4:0]  Flags;

    modport master (
        output In_valid, Op_a, Op_b, R_mode_in, Out_ready,
        input  In_ready, Out_valid, Result, Flags
    );

    modport slave (
        input  In_valid, Op_a, Op_b, R_mode_in, Out_ready,
        output In_ready, Out_valid, Result, Flags
    );
endinterface

// File: rtl/fpu_mul_issue_ctrl.sv
// Issue/capture sequencer around a combinational FP32 multiplier: holds unpacked operands
// for MUL_LATENCY cycles, captures the product and flags, and keeps sticky status flags.
module fpu_mul_issue_ctrl #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    fpu_mul_issue_ctrl_if.slave        bus,
    output logic                       Sx,
    output logic                       Sy,
    output logic [7:0]                 Ex,
    output logic [7:0]                 Ey,
    output logic [22:0]                Mx,
    output logic [22:0]                My,
    output logic [1:0]                 R_mode,
    output logic [1:0]                 Mul_enable,
    input  logic                       Sz,
    input  logic [7:0]                 Ez,
    input  logic [22:0]                Mz,
    input  logic [4:0]                 Flags_in,
    output logic [3:0]                 Flags_sticky,
    input  logic                       Flags_clear
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(MUL_LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [1:0]  rmode_q, rmode_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic [3:0]  sticky_q, sticky_d;
    logic        out_valid_q, out_valid_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rmode_q     <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            sticky_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rmode_q     <= rmode_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rmode_d     = rmode_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        // Clear takes effect first so a same-cycle capture still records its own flags.
        sticky_d    = Flags_clear ? 4'b0000 : sticky_q;

        unique case (state_q)
            StIdle: begin
                if (bus.In_valid) begin
                    op_a_d  = bus.Op_a;
                    op_b_d  = bus.Op_b;
                    rmode_d = bus.R_mode_in;
                    cnt_d   = CntLoad;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    result_d    = {Sz, Ez, Mz};
                    flags_d     = Flags_in;
                    sticky_d    = sticky_d | Flags_in[4:1];
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_valid_q && bus.Out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.In_ready  = (state_q == StIdle);
    assign bus.Out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Flags     = flags_q;
    assign Mul_enable    = (state_q == StBusy) ? 2'b11 : 2'b00;
    assign Flags_sticky  = sticky_q;

    assign Sx     = op_a_q[31];
    assign Ex     = op_a_q[30:23];
    assign Mx     = op_a_q[22:0];
    assign Sy     = op_b_q[31];
    assign Ey     = op_b_q[30:23];
    assign My     = op_b_q[22:0];
    assign R_mode = rmode_q;
endmodule

// File: tb/tb_fpu_mul_issue_ctrl.sv
// Directed bench for fpu_mul_issue_ctrl: one instance at latency 1, one at latency 3,
// each fed by a small lookup-table stand-in for the combinational multiplier.
module tb_fpu_mul_issue_ctrl;
    logic clk = 1'b0;
    logic rst1_n;
    logic rst3_n;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    fpu_mul_issue_ctrl_if bus1 ();
    fpu_mul_issue_ctrl_if bus3 ();

    logic        sx1, sy1, sz1, clr1;
    logic [7:0]  ex1, ey1, ez1;
    logic [22:0] mx1, my1, mz1;
    logic [1:0]  rm1, en1;
    logic [4:0]  fi1;
    logic [3:0]  st1;

    logic        sx3, sy3, sz3, clr3;
    logic [7:0]  ex3, ey3, ez3;
    logic [22:0] mx3, my3, mz3;
    logic [1:0]  rm3, en3;
    logic [4:0]  fi3;
    logic [3:0]  st3;

    fpu_mul_issue_ctrl #(.MUL_LATENCY(1)) u_dut1 (
        .CLK          (clk),
        .RST          (rst1_n),
        .bus          (bus1),
        .Sx           (sx1),
        .Sy           (sy1),
        .Ex           (ex1),
        .Ey           (ey1),
        .Mx           (mx1),
        .My           (my1),
        .R_mode       (rm1),
        .Mul_enable   (en1),
        .Sz           (sz1),
        .Ez           (ez1),
        .Mz           (mz1),
        .Flags_in     (fi1),
        .Flags_sticky (st1),
        .Flags_clear  (clr1)
    );

    fpu_mul_issue_ctrl #(.MUL_LATENCY(3)) u_dut3 (
        .CLK          (clk),
        .RST          (rst3_n),
        .bus          (bus3),
        .Sx           (sx3),
        .Sy           (sy3),
        .Ex           (ex3),
        .Ey           (ey3),
        .Mx           (mx3),
        .My           (my3),
        .R_mode       (rm3),
        .Mul_enable   (en3),
        .Sz           (sz3),
        .Ez           (ez3),
        .Mz           (mz3),
        .Flags_in     (fi3),
        .Flags_sticky (st3),
        .Flags_clear  (clr3)
    );

    // Returns {flags, product}; unknown operand pairs report invalid with a quiet NaN.
    function automatic logic [36:0] mul_stub(input logic [31:0] a, input logic [31:0] b);
        logic [36:0] r;
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: r = {5'b00000, 32'h40400000};
            {32'h3F800000, 32'h3F800000}: r = {5'b00000, 32'h3F800000};
            {32'h7F000000, 32'h7F000000}: r = {5'b01010, 32'h7F800000};
            default:                      r = {5'b10000, 32'h7FC00000};
        endcase
        return r;
    endfunction

    always_comb begin
        {fi1, sz1, ez1, mz1} = mul_stub({sx1, ex1, mx1}, {sy1, ey1, my1});
        {fi3, sz3, ez3, mz3} = mul_stub({sx3, ex3, mx3}, {sy3, ey3, my3});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        bus1.In_valid  = 1'b1;
        bus1.Op_a      = a;
        bus1.Op_b      = b;
        bus1.R_mode_in = rm;
        step();
        bus1.In_valid  = 1'b0;
    endtask

    task automatic issue3(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        bus3.In_valid  = 1'b1;
        bus3.Op_a      = a;
        bus3.Op_b      = b;
        bus3.R_mode_in = rm;
        step();
        bus3.In_valid  = 1'b0;
    endtask

    initial begin
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        clr1 = 1'b0;
        clr3 = 1'b0;
        bus1.In_valid = 1'b0; bus1.Op_a = '0; bus1.Op_b = '0; bus1.R_mode_in = '0;
        bus1.Out_ready = 1'b0;
        bus3.In_valid = 1'b0; bus3.Op_a = '0; bus3.Op_b = '0; bus3.R_mode_in = '0;
        bus3.Out_ready = 1'b0;
        #1;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus1.In_ready), 1);
        check("rst_out_valid", 32'(bus1.Out_valid), 0);
        check("rst_mul_en", 32'(en1), 0);
        check("rst_result", bus1.Result, 0);
        check("rst_sticky", 32'(st1), 0);
        check("rst_ex", 32'(ex1), 0);
        @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        step();

        // 1.5 * 2.0, latency 1
        bus1.Out_ready = 1'b1;
        issue1(32'h3FC00000, 32'h40000000, 2'b00);
        check("t1_ex", 32'(ex1), 'h7F);
        check("t1_ey", 32'(ey1), 'h80);
        check("t1_mx", 32'(mx1), 'h400000);
        check("t1_my", 32'(my1), 0);
        check("t1_busy_en", 32'(en1), 3);
        check("t1_busy_ready", 32'(bus1.In_ready), 0);
        check("t1_busy_valid", 32'(bus1.Out_valid), 0);
        step();
        check("t1_valid", 32'(bus1.Out_valid), 1);
        check("t1_result", bus1.Result, 'h40400000);
        check("t1_flags", 32'(bus1.Flags), 0);
        check("t1_sticky", 32'(st1), 0);
        check("t1_done_en", 32'(en1), 0);
        step();
        check("t1_idle_valid", 32'(bus1.Out_valid), 0);
        check("t1_idle_ready", 32'(bus1.In_ready), 1);

        // Downstream stall with an ignored In_valid
        bus1.Out_ready = 1'b0;
        issue1(32'h3F800000, 32'h3F800000, 2'b00);
        step();
        bus1.In_valid = 1'b1;
        bus1.Op_a     = 32'h7F000000;
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", 32'(bus1.Out_valid), 1);
            check("t2_stall_result", bus1.Result, 'h3F800000);
            check("t2_stall_ready", 32'(bus1.In_ready), 0);
            step();
        end
        check("t2_ignored_ex", 32'(ex1), 'h7F);
        bus1.In_valid  = 1'b0;
        bus1.Out_ready = 1'b1;
        step();
        check("t2_release_valid", 32'(bus1.Out_valid), 0);
        check("t2_release_ready", 32'(bus1.In_ready), 1);

        // Overflow flags become sticky; a clean op leaves them
        issue1(32'h7F000000, 32'h7F000000, 2'b00);
        step();
        check("t3_ovf_result", bus1.Result, 'h7F800000);
        check("t3_ovf_flags", 32'(bus1.Flags), 'h0A);
        check("t3_ovf_sticky", 32'(st1), 'h5);
        step();
        issue1(32'h3F800000, 32'h3F800000, 2'b00);
        step();
        check("t3_one_result", bus1.Result, 'h3F800000);
        check("t3_one_flags", 32'(bus1.Flags), 0);
        check("t3_one_sticky", 32'(st1), 'h5);
        step();

        // Sticky clear in idle and in the capture cycle
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check("t4_idle_clear", 32'(st1), 0);
        issue1(32'h00000000, 32'h12345678, 2'b00);
        step();
        check("t4_nan_result", bus1.Result, 'h7FC00000);
        check("t4_inv_sticky", 32'(st1), 'h8);
        step();
        issue1(32'h7F000000, 32'h7F000000, 2'b00);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check("t4_cap_clear_sticky", 32'(st1), 'h5);
        check("t4_cap_clear_flags", 32'(bus1.Flags), 'h0A);
        step();
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check("t4_idle_clear2", 32'(st1), 0);

        // Latency 3: operands held while the source changes
        bus3.Out_ready = 1'b1;
        issue3(32'h3FC00000, 32'h40000000, 2'b10);
        bus3.Op_a      = 32'h7F000000;
        bus3.R_mode_in = 2'b01;
        for (int i = 0; i < 3; i++) begin
            check("t5_en", 32'(en3), 3);
            check("t5_ex", 32'(ex3), 'h7F);
            check("t5_mx", 32'(mx3), 'h400000);
            check("t5_rmode", 32'(rm3), 2);
            check("t5_valid_low", 32'(bus3.Out_valid), 0);
            step();
        end
        check("t5_en_off", 32'(en3), 0);
        check("t5_valid", 32'(bus3.Out_valid), 1);
        check("t5_result", bus3.Result, 'h40400000);
        step();

        // Asynchronous reset during BUSY
        issue3(32'h7F000000, 32'h7F000000, 2'b00);
        step();
        step();
        step();
        check("t6_pre_sticky", 32'(st3), 'h5);
        step();
        issue3(32'h7F000000, 32'h7F000000, 2'b00);
        step();
        check("t6_busy_en", 32'(en3), 3);
        #2;
        rst3_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus3.Out_valid), 0);
        check("t6_async_en", 32'(en3), 0);
        check("t6_async_sticky", 32'(st3), 0);
        check("t6_async_ready", 32'(bus3.In_ready), 1);
        step();
        @(negedge clk);
        rst3_n = 1'b1;
        step();
        check("t6_post_ready", 32'(bus3.In_ready), 1);
        for (int i = 0; i < 6; i++) begin
            check("t6_no_stale_valid", 32'(bus3.Out_valid), 0);
            check("t6_no_stale_result", bus3.Result, 0);
            step();
        end
        check("t6_post_sticky", 32'(st3), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
